// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Every output comes from a flop, so ready_in never reaches ready_out combinationally.
module pipe_skid_stage #(
  parameter int unsigned DATA_W         = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in,
  output logic [1:0]        occ_out
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              ready_q;
  logic              valid_q;
  logic [1:0]        occ_q;
  logic              accept;

  assign accept = valid_in & ready_q;

  // ready/valid/occ are registered alongside the state rather than decoded from it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
    end else if (flush_in) begin
      // Flush beats any simultaneous accept; the incoming beat is dropped.
      state_q <= StEmpty;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      occ_q   <= 2'd0;
      if (CLEAR_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (valid_in) begin
            state_q <= StOne;
            main_q  <= data_in;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        StOne: begin
          if (accept && ready_in) begin
            main_q <= data_in;
          end else if (accept) begin
            // Downstream stalled: park the new beat behind the one on data_out.
            state_q <= StTwo;
            skid_q  <= data_in;
            ready_q <= 1'b0;
            occ_q   <= 2'd2;
          end else if (ready_in) begin
            state_q <= StEmpty;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
          end
        end
        StTwo: begin
          if (ready_in) begin
            state_q <= StOne;
            main_q  <= skid_q;
            ready_q <= 1'b1;
            occ_q   <= 2'd1;
          end
        end
        default: begin
          state_q <= StEmpty;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          occ_q   <= 2'd0;
        end
      endcase
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign data_out  = main_q;
  assign occ_out   = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a clearing 32-bit instance and a retaining 64-bit instance
// share stimulus and are checked every cycle against a queue model.
module tb_pipe_skid_stage;

  localparam int unsigned WA = 32;
  localparam int unsigned WB = 64;

  logic          clk_in   = 1'b0;
  logic          rst_in   = 1'b0;
  logic          flush_in = 1'b0;
  logic          valid_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [WB-1:0] data_in  = '0;

  logic          ready_a, valid_a;
  logic [WA-1:0] data_a;
  logic [1:0]    occ_a;
  logic          ready_b, valid_b;
  logic [WB-1:0] data_b;
  logic [1:0]    occ_b;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  pipe_skid_stage #(.DATA_W(WA), .CLEAR_ON_FLUSH(1'b1)) dut_a (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush_in),
    .valid_in  (valid_in),
    .data_in   (data_in[WA-1:0]),
    .ready_out (ready_a),
    .valid_out (valid_a),
    .data_out  (data_a),
    .ready_in  (ready_in),
    .occ_out   (occ_a)
  );

  pipe_skid_stage #(.DATA_W(WB), .CLEAR_ON_FLUSH(1'b0)) dut_b (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .flush_in  (flush_in),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_b),
    .valid_out (valid_b),
    .data_out  (data_b),
    .ready_in  (ready_in),
    .occ_out   (occ_b)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of held entries plus the value left visible once it runs dry.
  logic [WB-1:0] q[$];
  logic [WB-1:0] last_a = '0;
  logic [WB-1:0] last_b = '0;

  always @(posedge clk_in or negedge rst_in) begin
    bit acc;
    bit snd;
    if (!rst_in) begin
      q.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      acc = valid_in && (q.size() < 2);
      snd = (q.size() > 0) && ready_in;
      if (flush_in) begin
        if (q.size() > 0) last_b = q[0];
        last_a = '0;
        q.delete();
      end else begin
        if (snd) begin
          last_a = q.pop_front();
          last_b = last_a;
        end
        if (acc) q.push_back(data_in);
      end
    end
  end

  always @(negedge clk_in) begin
    logic [1:0]    e_occ;
    logic [WB-1:0] e_head_a;
    logic [WB-1:0] e_head_b;
    if (chk_en) begin
      e_occ    = 2'(q.size());
      e_head_a = (q.size() > 0) ? q[0] : last_a;
      e_head_b = (q.size() > 0) ? q[0] : last_b;
      check("model_a", {ready_a, valid_a, occ_a, data_a},
            {(q.size() < 2), (q.size() > 0), e_occ, e_head_a[WA-1:0]});
      check("model_b", {ready_b, valid_b, occ_b, data_b},
            {(q.size() < 2), (q.size() > 0), e_occ, e_head_b});
    end
  end

  task automatic drive(input logic v, input logic [WB-1:0] d, input logic r, input logic f);
    valid_in = v;
    data_in  = v ? d : 'x;
    ready_in = r;
    flush_in = f;
    @(posedge clk_in);
    #2;
  endtask

  task automatic lit_a(input string name, input logic r, input logic v, input logic [1:0] o,
                       input logic [WA-1:0] d);
    check(name, {ready_a, valid_a, occ_a, data_a}, {r, v, o, d});
  endtask

  initial begin
    logic [WB-1:0] rnd;
    repeat (2) @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    chk_en = 1'b1;
    lit_a("reset_state", 1'b1, 1'b0, 2'd0, 32'h0);

    // Streaming: one cycle latency, ready_out never drops.
    drive(1'b1, 64'h1, 1'b1, 1'b0);
    lit_a("stream_1", 1'b1, 1'b1, 2'd1, 32'h1);
    drive(1'b1, 64'h2, 1'b1, 1'b0);
    lit_a("stream_2", 1'b1, 1'b1, 2'd1, 32'h2);
    drive(1'b1, 64'h3, 1'b1, 1'b0);
    drive(1'b1, 64'h4, 1'b1, 1'b0);
    lit_a("stream_4", 1'b1, 1'b1, 2'd1, 32'h4);
    drive(1'b0, '0, 1'b1, 1'b0);
    lit_a("stream_drain", 1'b1, 1'b0, 2'd0, 32'h4);

    // Stall into the skid entry, offer C while full, then drain in order.
    drive(1'b1, 64'h0000_00A1, 1'b0, 1'b0);
    drive(1'b1, 64'h0000_00B2, 1'b0, 1'b0);
    lit_a("skid_full", 1'b0, 1'b1, 2'd2, 32'hA1);
    drive(1'b1, 64'h0000_00C3, 1'b0, 1'b0);
    lit_a("skid_hold", 1'b0, 1'b1, 2'd2, 32'hA1);
    ready_in = 1'b1;
    #1;
    check("no_comb_ready", {127'b0, ready_a}, 128'd0);
    drive(1'b1, 64'h0000_00C3, 1'b1, 1'b0);
    lit_a("skid_out_b", 1'b1, 1'b1, 2'd1, 32'hB2);
    drive(1'b1, 64'h0000_00C3, 1'b1, 1'b0);
    lit_a("skid_out_c", 1'b1, 1'b1, 2'd1, 32'hC3);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Flush with two held plus an incoming beat that must vanish.
    drive(1'b1, 64'h1111_0000_0000_00AA, 1'b0, 1'b0);
    drive(1'b1, 64'h2222_0000_0000_00BB, 1'b0, 1'b0);
    drive(1'b1, 64'h3333_0000_0000_00DD, 1'b1, 1'b1);
    lit_a("flush_clear", 1'b1, 1'b0, 2'd0, 32'h0);
    check("flush_keep_b", data_b, 64'h1111_0000_0000_00AA);
    drive(1'b0, '0, 1'b1, 1'b0);
    lit_a("flush_no_d", 1'b1, 1'b0, 2'd0, 32'h0);

    // Retaining instance keeps its payload across a flush.
    drive(1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("retain_data", data_b, 64'h0000_0000_DEAD_BEEF);
    check("retain_valid", {127'b0, valid_b}, 128'd0);

    // Asynchronous reset from the full state, observed before any clock edge.
    drive(1'b1, 64'h0000_00E1, 1'b0, 1'b0);
    drive(1'b1, 64'h0000_00E2, 1'b0, 1'b0);
    #1;
    rst_in = 1'b0;
    #1;
    lit_a("async_reset", 1'b1, 1'b0, 2'd0, 32'h0);
    check("async_reset_b", {ready_b, valid_b, occ_b, data_b}, {1'b1, 1'b0, 2'd0, 64'h0});
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    lit_a("reset_release", 1'b1, 1'b0, 2'd0, 32'h0);

    // Random handshakes with occasional flushes; X payload whenever valid_in is low.
    for (int i = 0; i < 4000; i++) begin
      rnd = {$urandom(), $urandom()};
      drive(($urandom_range(0, 3) != 0), rnd, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 60) == 0));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
